// File: rtl/core_dbg_pkg.sv
// rtl/core_dbg_pkg.sv - shared types and helpers for the multi-core debug APB bridge
package core_dbg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEFAULT_TIMEOUT = 255;

   function automatic int core_sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/core_dbg_apb_mc_if.sv
// rtl/core_dbg_apb_mc_if.sv - APB slave bus plus per-core debug request bus
interface core_dbg_apb_mc_if #(
   parameter int NUM_CORES      = 4,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32
);
   localparam int ADDR_WIDTH = REG_ADDR_WIDTH + core_dbg_pkg::core_sel_w(NUM_CORES);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0]           paddr;
   logic                            psel;
   logic                            penable;
   logic                            pwrite;
   logic [DATA_WIDTH-1:0]           pwdata;
   logic [STRB_WIDTH-1:0]           pstrb;
   logic                            pready;
   logic [DATA_WIDTH-1:0]           prdata;
   logic                            pslverr;

   logic [NUM_CORES-1:0]            dbg_req;
   logic                            dbg_wr;
   logic [REG_ADDR_WIDTH-1:0]       dbg_addr;
   logic [DATA_WIDTH-1:0]           dbg_wdata;
   logic [STRB_WIDTH-1:0]           dbg_strb;
   logic [NUM_CORES-1:0]            dbg_ack;
   logic [NUM_CORES*DATA_WIDTH-1:0] dbg_rdata;
   logic [NUM_CORES-1:0]            dbg_err;

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr,
      output dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_strb,
      input  dbg_ack, dbg_rdata, dbg_err
   );

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr,
      input  dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_strb,
      output dbg_ack, dbg_rdata, dbg_err
   );

endinterface

// File: rtl/core_dbg_timeout.sv
// rtl/core_dbg_timeout.sv - clearable wait counter that flags the last allowed cycle
module core_dbg_timeout #(
   parameter int TIMEOUT = core_dbg_pkg::DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // TIMEOUT=0 means wait forever, so expiry never fires
   assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/core_dbg_apb_mc.sv
// rtl/core_dbg_apb_mc.sv - APB4 slave bridging debug accesses to NUM_CORES core debug ports
module core_dbg_apb_mc
   import core_dbg_pkg::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT        = DEFAULT_TIMEOUT
) (
   input logic              clk,
   input logic              rst_n,
   core_dbg_apb_mc_if.slave bus
);
   localparam int CORE_SEL_W = core_sel_w(NUM_CORES);
   localparam int ADDR_WIDTH = REG_ADDR_WIDTH + CORE_SEL_W;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   state_e                    state_q;
   logic [CORE_SEL_W-1:0]     idx_q;
   logic                      pready_q;
   logic                      pslverr_q;
   logic [DATA_WIDTH-1:0]     prdata_q;
   logic [NUM_CORES-1:0]      req_q;
   logic                      wr_q;
   logic [REG_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [STRB_WIDTH-1:0]     strb_q;

   logic [CORE_SEL_W-1:0]     sel_idx;
   logic                      sel_bad;
   logic                      ack;
   logic                      err;
   logic [DATA_WIDTH-1:0]     rdata;
   logic                      expired;

   assign sel_idx = bus.paddr[ADDR_WIDTH-1:REG_ADDR_WIDTH];
   assign sel_bad = {1'b0, sel_idx} >= (CORE_SEL_W + 1)'(NUM_CORES);
   assign ack     = bus.dbg_ack[idx_q];
   assign err     = bus.dbg_err[idx_q];
   assign rdata   = bus.dbg_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

   core_dbg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q != REQ),
      .en_i      (state_q == REQ),
      .expired_o (expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         req_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.psel && !bus.penable) begin
                  idx_q   <= sel_idx;
                  wr_q    <= bus.pwrite;
                  addr_q  <= bus.paddr[REG_ADDR_WIDTH-1:0];
                  wdata_q <= bus.pwdata;
                  strb_q  <= bus.pwrite ? bus.pstrb : '0;
                  if (sel_bad) begin
                     pready_q  <= 1'b1;
                     pslverr_q <= 1'b1;
                     prdata_q  <= '0;
                     state_q   <= RESP;
                  end else if (bus.pwrite && (bus.pstrb == '0)) begin
                     pready_q  <= 1'b1;
                     pslverr_q <= 1'b0;
                     state_q   <= RESP;
                  end else begin
                     req_q   <= NUM_CORES'(1) << sel_idx;
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               // master dropped psel mid-transfer: abandon silently
               if (!bus.psel) begin
                  req_q   <= '0;
                  state_q <= IDLE;
               end else if (ack) begin
                  req_q     <= '0;
                  pready_q  <= 1'b1;
                  pslverr_q <= err;
                  prdata_q  <= (!wr_q && !err) ? rdata : '0;
                  state_q   <= RESP;
               end else if (expired) begin
                  req_q     <= '0;
                  pready_q  <= 1'b1;
                  pslverr_q <= 1'b1;
                  prdata_q  <= '0;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pready    = pready_q;
   assign bus.pslverr   = pslverr_q;
   assign bus.prdata    = prdata_q;
   assign bus.dbg_req   = req_q;
   assign bus.dbg_wr    = wr_q;
   assign bus.dbg_addr  = addr_q;
   assign bus.dbg_wdata = wdata_q;
   assign bus.dbg_strb  = strb_q;

endmodule
